// File: rtl/timer_core.sv
// ---------------------------------------------------------------------------
// timer_core
// MM:SS countdown timer: loads seconds then minutes from sw, counts down once
// per tick, pauses/resumes on toggle and blinks the display when it expires.
//
// Ports
//   CLOCK_50      in   system clock, all state on its rising edge
//   reset         in   synchronous, active-high
//   tick          in   1 Hz single-cycle pulse
//   set_pulse     in   single-cycle set button pulse
//   toggle_pulse  in   single-cycle start/stop button pulse
//   sw[7:0]       in   BCD load value, [7:4] tens, [3:0] ones
//   min_bcd[7:0]  out  minutes, BCD 00..99
//   sec_bcd[7:0]  out  seconds, BCD 00..59
//   display_on    out  1 = segments lit, 0 = blanked
//   running       out  1 in RUN
//   done          out  1 in DONE
//   state[2:0]    out  current state encoding
//
// State  | meaning
// -------+-----------------------------------------------------
// SET_SEC| waiting for set_pulse to load seconds
// SET_MIN| waiting for set_pulse to load minutes
// RUN    | counting down on tick
// PAUSE  | value frozen, toggle resumes
// DONE   | reached 00:00, display blinks every BLINK_TICKS ticks
// ---------------------------------------------------------------------------
module timer_core #(
    parameter int unsigned BLINK_TICKS = 1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       tick,
    input  logic       set_pulse,
    input  logic       toggle_pulse,
    input  logic [7:0] sw,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       display_on,
    output logic       running,
    output logic       done,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        SET_SEC = 3'd0,
        SET_MIN = 3'd1,
        RUN     = 3'd2,
        PAUSE   = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam logic [3:0] BLINK_LIM = 4'(BLINK_TICKS);

    state_e     state_q, state_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       disp_q, disp_d;
    logic [3:0] blink_q, blink_d;

    logic [7:0] sec_dec;
    logic [7:0] min_dec;
    logic       sec_wrap;
    logic       dec_zero;
    logic       is_zero;

    function automatic logic [7:0] clamp_sec(input logic [7:0] v);
        if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return 8'h59;
        return v;
    endfunction

    function automatic logic [7:0] clamp_min(input logic [7:0] v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return 8'h99;
        return v;
    endfunction

    // Saturates at 00 so the minutes digit can never underflow.
    function automatic logic [7:0] bcd_dec99(input logic [7:0] v);
        if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
        if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return 8'h00;
    endfunction

    always_comb begin
        sec_wrap = (sec_q == 8'h00);
        if (sec_q[3:0] != 4'd0) begin
            sec_dec = {sec_q[7:4], sec_q[3:0] - 4'd1};
        end else if (sec_q[7:4] != 4'd0) begin
            sec_dec = {sec_q[7:4] - 4'd1, 4'd9};
        end else begin
            sec_dec = 8'h59;
        end
        min_dec  = sec_wrap ? bcd_dec99(min_q) : min_q;
        dec_zero = (min_dec == 8'h00) && (sec_dec == 8'h00);
        is_zero  = (min_q == 8'h00) && (sec_q == 8'h00);
    end

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        disp_d  = 1'b1;
        blink_d = 4'd0;

        unique case (state_q)
            SET_SEC: begin
                if (set_pulse) begin
                    sec_d   = clamp_sec(sw);
                    state_d = SET_MIN;
                end
            end
            SET_MIN: begin
                if (set_pulse) begin
                    min_d   = clamp_min(sw);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (set_pulse) begin
                    state_d = SET_SEC;
                    min_d   = 8'h00;
                    sec_d   = 8'h00;
                end else if (is_zero) begin
                    // Entered RUN with nothing to count: expire immediately.
                    state_d = DONE;
                end else if (tick) begin
                    // A same-edge toggle still pauses after the decrement,
                    // unless the decrement expires the timer.
                    min_d = min_dec;
                    sec_d = sec_dec;
                    if (dec_zero) begin
                        state_d = DONE;
                    end else if (toggle_pulse) begin
                        state_d = PAUSE;
                    end
                end else if (toggle_pulse) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (set_pulse) begin
                    state_d = SET_SEC;
                    min_d   = 8'h00;
                    sec_d   = 8'h00;
                end else if (toggle_pulse) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                disp_d  = disp_q;
                blink_d = blink_q;
                if (set_pulse) begin
                    state_d = SET_SEC;
                    min_d   = 8'h00;
                    sec_d   = 8'h00;
                    disp_d  = 1'b1;
                    blink_d = 4'd0;
                end else if (tick) begin
                    if (blink_q + 4'd1 >= BLINK_LIM) begin
                        blink_d = 4'd0;
                        disp_d  = ~disp_q;
                    end else begin
                        blink_d = blink_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = SET_SEC;
                min_d   = 8'h00;
                sec_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= SET_SEC;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            disp_q  <= 1'b1;
            blink_q <= 4'd0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            disp_q  <= disp_d;
            blink_q <= blink_d;
        end
    end

    assign min_bcd    = min_q;
    assign sec_bcd    = sec_q;
    assign display_on = disp_q;
    assign running    = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign state      = state_q;

endmodule

// File: tb/tb_timer_core.sv
// ---------------------------------------------------------------------------
// tb_timer_core
// Self-checking bench for timer_core (BLINK_TICKS = 1). Each test task builds
// a list of single-cycle stimulus steps; steps flagged for checking push the
// expected {state, min, sec, display_on, running, done} onto a scoreboard
// queue, which is popped and compared one clock edge later.
// ---------------------------------------------------------------------------
module tb_timer_core;

    localparam logic [2:0] SS = 3'd0;
    localparam logic [2:0] SM = 3'd1;
    localparam logic [2:0] RN = 3'd2;
    localparam logic [2:0] PS = 3'd3;
    localparam logic [2:0] DN = 3'd4;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       set_pulse = 1'b0;
    logic       toggle_pulse = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       display_on;
    logic       running;
    logic       done;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        r, s, t, k;
        logic [7:0]  v;
        bit          chk;
        string       name;
        logic [21:0] exp;
    } step_t;

    typedef struct {
        string       name;
        logic [21:0] exp;
    } sb_t;

    step_t steps[$];
    sb_t   sb[$];

    timer_core #(.BLINK_TICKS(1)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .tick         (tick),
        .set_pulse    (set_pulse),
        .toggle_pulse (toggle_pulse),
        .sw           (sw),
        .min_bcd      (min_bcd),
        .sec_bcd      (sec_bcd),
        .display_on   (display_on),
        .running      (running),
        .done         (done),
        .state        (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [21:0] pk(input logic [2:0] st, input logic [7:0] mn,
                                       input logic [7:0] sc, input logic dp);
        return {st, mn, sc, dp, st == RN, st == DN};
    endfunction

    function automatic logic [21:0] obs();
        return {state, min_bcd, sec_bcd, display_on, running, done};
    endfunction

    task automatic add(input logic r, input logic s, input logic t, input logic k,
                       input logic [7:0] v, input bit chk, input string nm,
                       input logic [2:0] st, input logic [7:0] mn,
                       input logic [7:0] sc, input logic dp);
        step_t x;
        x.r = r; x.s = s; x.t = t; x.k = k; x.v = v;
        x.chk = chk; x.name = nm; x.exp = pk(st, mn, sc, dp);
        steps.push_back(x);
    endtask

    // Drives one cycle of inputs, then releases the pulses 1 ns after the edge.
    task automatic cyc(input step_t x);
        reset = x.r; set_pulse = x.s; toggle_pulse = x.t; tick = x.k; sw = x.v;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0; set_pulse = 1'b0; toggle_pulse = 1'b0; tick = 1'b0;
    endtask

    task automatic test_reset();
        sb_t e;
        steps.delete();
        add(1, 0, 0, 0, 8'h00, 1, "reset",           SS, 8'h00, 8'h00, 1);
        add(0, 0, 1, 1, 8'h00, 1, "setsec_ignore",   SS, 8'h00, 8'h00, 1);
        for (int i = 0; i < steps.size(); i++) begin
            if (steps[i].chk) sb.push_back('{steps[i].name, steps[i].exp});
            cyc(steps[i]);
            if (steps[i].chk) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s got %h expected %h", e.name, obs(), e.exp);
                end
            end
        end
    endtask

    task automatic test_load_run();
        sb_t e;
        steps.delete();
        add(0, 1, 0, 0, 8'h45, 1, "load_sec",        SM, 8'h00, 8'h45, 1);
        add(0, 0, 1, 0, 8'h00, 1, "setmin_ign_tog",  SM, 8'h00, 8'h45, 1);
        add(0, 0, 0, 1, 8'h00, 1, "setmin_ign_tick", SM, 8'h00, 8'h45, 1);
        add(0, 1, 0, 0, 8'h02, 1, "load_min",        RN, 8'h02, 8'h45, 1);
        add(0, 0, 0, 1, 8'h00, 1, "tick1",           RN, 8'h02, 8'h44, 1);
        for (int i = 0; i < 43; i++)
            add(0, 0, 0, 1, 8'h00, 0, "", RN, 8'h00, 8'h00, 1);
        add(0, 0, 0, 1, 8'h00, 1, "tick45",          RN, 8'h02, 8'h00, 1);
        add(0, 0, 0, 1, 8'h00, 1, "tick46",          RN, 8'h01, 8'h59, 1);
        add(0, 1, 0, 0, 8'h00, 1, "run_set_clear",   SS, 8'h00, 8'h00, 1);
        for (int i = 0; i < steps.size(); i++) begin
            if (steps[i].chk) sb.push_back('{steps[i].name, steps[i].exp});
            cyc(steps[i]);
            if (steps[i].chk) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s got %h expected %h", e.name, obs(), e.exp);
                end
            end
        end
    endtask

    task automatic test_done_blink();
        sb_t e;
        steps.delete();
        add(0, 1, 0, 0, 8'h03, 1, "d_load_sec",      SM, 8'h00, 8'h03, 1);
        add(0, 1, 0, 0, 8'h00, 1, "d_load_min",      RN, 8'h00, 8'h03, 1);
        add(0, 0, 0, 1, 8'h00, 1, "d_tick1",         RN, 8'h00, 8'h02, 1);
        add(0, 0, 0, 1, 8'h00, 1, "d_tick2",         RN, 8'h00, 8'h01, 1);
        add(0, 0, 0, 1, 8'h00, 1, "d_tick3_done",    DN, 8'h00, 8'h00, 1);
        add(0, 0, 0, 0, 8'h00, 1, "d_hold",          DN, 8'h00, 8'h00, 1);
        add(0, 0, 0, 1, 8'h00, 1, "blink_off",       DN, 8'h00, 8'h00, 0);
        add(0, 0, 0, 1, 8'h00, 1, "blink_on",        DN, 8'h00, 8'h00, 1);
        add(0, 0, 1, 0, 8'h00, 1, "done_ign_tog",    DN, 8'h00, 8'h00, 1);
        add(0, 0, 0, 1, 8'h00, 1, "blink_off2",      DN, 8'h00, 8'h00, 0);
        add(0, 1, 0, 0, 8'h00, 1, "done_set",        SS, 8'h00, 8'h00, 1);
        for (int i = 0; i < steps.size(); i++) begin
            if (steps[i].chk) sb.push_back('{steps[i].name, steps[i].exp});
            cyc(steps[i]);
            if (steps[i].chk) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s got %h expected %h", e.name, obs(), e.exp);
                end
            end
        end
    endtask

    task automatic test_clamp();
        sb_t e;
        steps.delete();
        add(0, 1, 0, 0, 8'h7A, 1, "clamp_sec_7A",    SM, 8'h00, 8'h59, 1);
        add(0, 1, 0, 0, 8'hA3, 1, "clamp_min_A3",    RN, 8'h99, 8'h59, 1);
        add(0, 0, 0, 1, 8'h00, 1, "tick_9959",       RN, 8'h99, 8'h58, 1);
        add(0, 1, 0, 0, 8'h00, 1, "clamp_clear",     SS, 8'h00, 8'h00, 1);
        add(0, 1, 0, 0, 8'h69, 1, "clamp_sec_69",    SM, 8'h00, 8'h59, 1);
        add(0, 1, 0, 0, 8'h5F, 1, "clamp_min_5F",    RN, 8'h99, 8'h59, 1);
        add(0, 1, 0, 0, 8'h00, 1, "clamp_clear2",    SS, 8'h00, 8'h00, 1);
        add(0, 1, 0, 0, 8'h59, 1, "noclamp_sec_59",  SM, 8'h00, 8'h59, 1);
        add(0, 1, 0, 0, 8'h98, 1, "noclamp_min_98",  RN, 8'h98, 8'h59, 1);
        add(0, 1, 0, 0, 8'h00, 1, "clamp_clear3",    SS, 8'h00, 8'h00, 1);
        for (int i = 0; i < steps.size(); i++) begin
            if (steps[i].chk) sb.push_back('{steps[i].name, steps[i].exp});
            cyc(steps[i]);
            if (steps[i].chk) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s got %h expected %h", e.name, obs(), e.exp);
                end
            end
        end
    endtask

    task automatic test_pause();
        sb_t e;
        steps.delete();
        add(0, 1, 0, 0, 8'h10, 1, "p_load_sec",      SM, 8'h00, 8'h10, 1);
        add(0, 1, 0, 0, 8'h01, 1, "p_load_min",      RN, 8'h01, 8'h10, 1);
        add(0, 0, 1, 0, 8'h00, 1, "pause",           PS, 8'h01, 8'h10, 1);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 1, 8'h00, 0, "", PS, 8'h00, 8'h00, 1);
        add(0, 0, 0, 1, 8'h00, 1, "pause_5ticks",    PS, 8'h01, 8'h10, 1);
        add(0, 0, 1, 0, 8'h00, 1, "resume",          RN, 8'h01, 8'h10, 1);
        add(0, 0, 0, 1, 8'h00, 1, "resume_tick",     RN, 8'h01, 8'h09, 1);
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 1, 8'h00, 0, "", RN, 8'h00, 8'h00, 1);
        add(0, 0, 0, 1, 8'h00, 1, "tick_to_0100",    RN, 8'h01, 8'h00, 1);
        add(0, 0, 0, 1, 8'h00, 1, "tick_to_0059",    RN, 8'h00, 8'h59, 1);
        add(0, 1, 0, 0, 8'h00, 1, "p_clear",         SS, 8'h00, 8'h00, 1);
        for (int i = 0; i < steps.size(); i++) begin
            if (steps[i].chk) sb.push_back('{steps[i].name, steps[i].exp});
            cyc(steps[i]);
            if (steps[i].chk) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s got %h expected %h", e.name, obs(), e.exp);
                end
            end
        end
    endtask

    task automatic test_same_edge();
        sb_t e;
        steps.delete();
        add(0, 1, 0, 0, 8'h05, 1, "s_load_sec",      SM, 8'h00, 8'h05, 1);
        add(0, 1, 0, 0, 8'h00, 1, "s_load_min",      RN, 8'h00, 8'h05, 1);
        add(0, 0, 1, 1, 8'h00, 1, "tick_tog_pause",  PS, 8'h00, 8'h04, 1);
        add(0, 0, 1, 0, 8'h00, 1, "s_resume",        RN, 8'h00, 8'h04, 1);
        add(0, 0, 0, 1, 8'h00, 0, "",                RN, 8'h00, 8'h00, 1);
        add(0, 0, 0, 1, 8'h00, 0, "",                RN, 8'h00, 8'h00, 1);
        add(0, 0, 0, 1, 8'h00, 1, "s_at_0001",       RN, 8'h00, 8'h01, 1);
        add(0, 0, 1, 1, 8'h00, 1, "tick_tog_done",   DN, 8'h00, 8'h00, 1);
        add(0, 1, 1, 0, 8'h00, 1, "done_set_tog",    SS, 8'h00, 8'h00, 1);
        add(0, 1, 0, 0, 8'h05, 1, "s2_load_sec",     SM, 8'h00, 8'h05, 1);
        add(0, 1, 0, 0, 8'h00, 1, "s2_load_min",     RN, 8'h00, 8'h05, 1);
        add(0, 0, 1, 0, 8'h00, 1, "s2_pause",        PS, 8'h00, 8'h05, 1);
        add(0, 1, 1, 0, 8'h00, 1, "pause_set_tog",   SS, 8'h00, 8'h00, 1);
        add(0, 1, 0, 0, 8'h05, 0, "",                SM, 8'h00, 8'h05, 1);
        add(0, 1, 0, 0, 8'h00, 0, "",                RN, 8'h00, 8'h05, 1);
        add(0, 1, 0, 1, 8'h00, 1, "run_set_tick",    SS, 8'h00, 8'h00, 1);
        for (int i = 0; i < steps.size(); i++) begin
            if (steps[i].chk) sb.push_back('{steps[i].name, steps[i].exp});
            cyc(steps[i]);
            if (steps[i].chk) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s got %h expected %h", e.name, obs(), e.exp);
                end
            end
        end
    endtask

    task automatic test_zero_load();
        sb_t e;
        steps.delete();
        add(0, 1, 0, 0, 8'h00, 1, "z_load_sec",      SM, 8'h00, 8'h00, 1);
        add(0, 1, 0, 0, 8'h00, 1, "z_enter_run",     RN, 8'h00, 8'h00, 1);
        add(0, 0, 0, 0, 8'h00, 1, "z_auto_done",     DN, 8'h00, 8'h00, 1);
        add(0, 1, 0, 0, 8'h00, 1, "z_clear",         SS, 8'h00, 8'h00, 1);
        for (int i = 0; i < steps.size(); i++) begin
            if (steps[i].chk) sb.push_back('{steps[i].name, steps[i].exp});
            cyc(steps[i]);
            if (steps[i].chk) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s got %h expected %h", e.name, obs(), e.exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        sb_t e;
        steps.delete();
        add(0, 1, 0, 0, 8'h30, 1, "r_load_sec",      SM, 8'h00, 8'h30, 1);
        add(0, 1, 0, 0, 8'h00, 1, "r_load_min",      RN, 8'h00, 8'h30, 1);
        add(1, 1, 0, 1, 8'h00, 1, "reset_in_run",    SS, 8'h00, 8'h00, 1);
        add(0, 1, 0, 0, 8'h01, 0, "",                SM, 8'h00, 8'h01, 1);
        add(0, 1, 0, 0, 8'h00, 1, "r2_run",          RN, 8'h00, 8'h01, 1);
        add(0, 0, 0, 1, 8'h00, 1, "r2_done",         DN, 8'h00, 8'h00, 1);
        add(0, 0, 0, 1, 8'h00, 1, "r2_blank",        DN, 8'h00, 8'h00, 0);
        add(1, 0, 1, 1, 8'h00, 1, "reset_in_done",   SS, 8'h00, 8'h00, 1);
        add(0, 1, 0, 0, 8'h12, 1, "r3_load_sec",     SM, 8'h00, 8'h12, 1);
        add(1, 0, 0, 0, 8'h00, 1, "reset_in_setmin", SS, 8'h00, 8'h00, 1);
        for (int i = 0; i < steps.size(); i++) begin
            if (steps[i].chk) sb.push_back('{steps[i].name, steps[i].exp});
            cyc(steps[i]);
            if (steps[i].chk) begin
                e = sb.pop_front();
                n_checks++;
                if (obs() !== e.exp) begin
                    n_errors++;
                    $display("FAIL %s got %h expected %h", e.name, obs(), e.exp);
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge CLOCK_50);
        #1;
        test_reset();
        test_load_run();
        test_done_blink();
        test_clamp();
        test_pause();
        test_same_edge();
        test_zero_load();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_core.md
# timer_core

Countdown timer datapath and control for the board-level timer. Sits directly downstream of the clock divider. Consumes its once-per-second tick plus debounced, single-cycle button pulses and the switch value. Produces the current MM:SS as registered BCD digits for the seven-segment decoders, and status flags for LEDR.

## Interface
- BLINK_TICKS, default 1: number of ticks each blink phase lasts in DONE (1..15).
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; sampled on CLOCK_50.
- tick  in  1  one-cycle pulse at 1 Hz from the divider, already synchronous to CLOCK_50.
- set_pulse  in  1  one-cycle pulse, debounced set button.
- toggle_pulse  in  1  one-cycle pulse, debounced start/stop button.
- sw  in  8  BCD value to load: [7:4] tens digit, [3:0] ones digit.
- min_bcd  out  8  minutes, BCD 00–99.
- sec_bcd  out  8  seconds, BCD 00–59.
- display_on  out  1  1 = segments lit, 0 = blanked (blink phase).
- running  out  1  1 while in RUN.
- done  out  1  1 while in DONE.
- state  out  3  SET_SEC=0, SET_MIN=1, RUN=2, PAUSE=3, DONE=4.

## Operation
- After reset: state SET_SEC, min_bcd=00, sec_bcd=00, display_on=1, running=0, done=0, blink counter=0.
- Load clamp:
  - Seconds load: if sw[7:4]>5 or sw[3:0]>9, load 59; else load sw.
  - Minutes load: if either nibble >9, load 99; else load sw.
- SET_SEC: set_pulse loads sec_bcd from sw (clamped), then goes to SET_MIN. Toggle and tick are ignored.
- SET_MIN: set_pulse loads min_bcd from sw (clamped), then goes to RUN. Toggle and tick are ignored.
- RUN:
  - tick decrements MM:SS by one second in BCD:
    - ones digit 0 → 9 with tens digit −1;
    - sec 00 → 59 with min −1.
  - If the post-decrement value is 00:00, go to DONE on the same edge.
  - toggle_pulse → PAUSE.
  - set_pulse → SET_SEC, with min and sec cleared to 00.
  - If RUN is entered with 00:00, go to DONE on the next edge without waiting for a tick.
- PAUSE: value held. toggle_pulse → RUN; set_pulse → SET_SEC (clear to 00:00). Tick is ignored.
- DONE:
  - Value held at 00:00.
  - Each tick advances the blink counter; every BLINK_TICKS ticks, display_on inverts and the counter clears.
  - set_pulse → SET_SEC with display_on=1.
  - toggle_pulse is ignored.
- Simultaneous-event priority: reset > set_pulse > toggle_pulse > tick.
  - Exception: in RUN, when tick and toggle_pulse arrive on the same edge, both take effect: decrement, then PAUSE. If the decrement reaches 00:00, go to DONE, not PAUSE.
- display_on is 1 in every state except DONE.
- Entering DONE starts the blink phase with display_on=1 and the counter at 0.
- Digits never leave their legal BCD ranges; no decrement below 00:00.

## Timing
- All outputs are registered. Output changes appear the cycle after the triggering input edge (1-cycle latency).
- running, done and state are decoded from the registered state and update on the same edge as the transition.
- Input pulses are assumed one cycle wide. A pulse held high for N cycles is treated as N events; the upstream debouncer guarantees one cycle.
- reset asserted mid-operation (any state) returns to the reset values on the next edge, regardless of other inputs.
- No combinational path from any input to any output.

## Test plan
- Reset, then sw=8'h45 + set, sw=8'h02 + set → state=RUN with min=02, sec=45. After 1 tick, 02:44. After 45 ticks total, 02:00. After 46 ticks, 01:59.
- Load 00:03 and run 3 ticks → 00:02, 00:01, then 00:00 with done=1 and state=DONE one cycle after the third tick. With BLINK_TICKS=1, display_on toggles on each later tick. A set pulse then gives SET_SEC, 00:00, display_on=1.
- Clamp: sec sw=8'h7A → 59; min sw=8'hA3 → 99. Load 99:59 and tick once → 99:58.
- Pause/resume: in RUN at 01:10, toggle → PAUSE. Five ticks leave 01:10. Toggle → RUN, and the next tick gives 01:09.
- Same-edge events:
  - tick+toggle at 00:05 → 00:04 and PAUSE.
  - tick+toggle at 00:01 → 00:00 and DONE.
  - set+toggle in PAUSE → SET_SEC.
  - Load 00:00 in both phases → DONE one cycle after entering RUN.
- Reset asserted in RUN at 00:30 together with set_pulse and tick → next cycle SET_SEC, 00:00, display_on=1, running=0.
